// File: rtl/rr_arb_pkg.sv
// Shared helpers for the parameterised round-robin arbiter: index width,
// quota-field extraction, pointer reset value and the implied arbiter state.
package rr_arb_pkg;

    localparam int MAX_N  = 32;
    localparam int MAX_QW = 16;
    localparam int QUOTA_BUS_W = MAX_N * MAX_QW;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } arb_state_e;

    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // The pointer resets to the last index so requester 0 is scanned first.
    function automatic int ptr_reset_val(input int n);
        return n - 1;
    endfunction

    function automatic int unsigned quota_field(input logic [QUOTA_BUS_W-1:0] q_all,
                                                input int idx,
                                                input int qw);
        int unsigned f;
        f = 0;
        for (int b = 0; b < MAX_QW; b++) begin
            if (b < qw) begin
                f[b] = q_all[idx * qw + b];
            end
        end
        return f;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin pick: first set bit of mask strictly after ptr, wrapping at N-1.
module rr_pick
    import rr_arb_pkg::*;
#(
    parameter int N    = 4,
    parameter int IDXW = idx_width(N)
) (
    input  logic [N-1:0]    mask,
    input  logic [IDXW-1:0] ptr,
    output logic            found,
    output logic [IDXW-1:0] winner
);

    logic [N-1:0] rot;

    always_comb begin
        // NOTE: every output gets a default before any branch, so no latch is inferred.
        found  = 1'b0;
        winner = '0;
        rot    = N'({mask, mask} >> (int'(ptr) + 1));
        // Descending scan so the lowest rotated position wins.
        for (int j = N - 1; j >= 0; j--) begin
            if (rot[j]) begin
                found  = 1'b1;
                winner = IDXW'((int'(ptr) + 1 + j) % N);
            end
        end
    end

endmodule

// File: rtl/rr_arbiter_param.sv
// N-way round-robin arbiter with per-requester burst quotas and a registered
// one-hot grant; the owner is released as soon as its request drops.
module rr_arbiter_param
    import rr_arb_pkg::*;
#(
    parameter  int N    = 4,
    parameter  int QW   = 4,
    localparam int IDXW = idx_width(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic [N*QW-1:0] quota,
    output logic [N-1:0]    grant,
    output logic            grant_valid,
    output logic [IDXW-1:0] grant_idx
);

    localparam logic [IDXW-1:0] PTR_RST = IDXW'(ptr_reset_val(N));

    arb_state_e            state;
    logic [IDXW-1:0]       ptr;
    logic [QW-1:0]         burst_cnt;
    logic [N-1:0]          grant_d;
    logic [IDXW-1:0]       idx_d;
    logic [IDXW-1:0]       ptr_d;
    logic [QW-1:0]         cnt_d;
    logic [QUOTA_BUS_W-1:0] quota_ext;
    logic [QW-1:0]         owner_quota;
    logic [QW-1:0]         eff_quota;
    logic                  owner_req;
    logic                  quota_spent;
    logic [N-1:0]          pick_mask;
    logic                  pick_found;
    logic [IDXW-1:0]       pick_idx;

    assign quota_ext   = QUOTA_BUS_W'(quota);
    assign owner_quota = QW'(quota_field(quota_ext, int'(grant_idx), QW));
    assign eff_quota   = (owner_quota == '0) ? QW'(1) : owner_quota;
    assign owner_req   = |(req & grant);
    assign quota_spent = burst_cnt >= eff_quota;
    // An exhausted owner is masked out so the scan hands over to someone else.
    assign pick_mask   = (owner_req && quota_spent) ? (req & ~grant) : req;

    rr_pick #(.N(N), .IDXW(IDXW)) u_pick (
        .mask   (pick_mask),
        .ptr    (ptr),
        .found  (pick_found),
        .winner (pick_idx)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant     <= '0;
            grant_idx <= '0;
            ptr       <= PTR_RST;
            burst_cnt <= '0;
        end else begin
            // NOTE: non-blocking updates keep all registers sampling the same pre-edge values.
            grant     <= grant_d;
            grant_idx <= idx_d;
            ptr       <= ptr_d;
            burst_cnt <= cnt_d;
        end
    end

    always_comb begin
        grant_d = grant;
        idx_d   = grant_idx;
        ptr_d   = ptr;
        cnt_d   = burst_cnt;
        if (state == ST_OWNED && owner_req && !quota_spent) begin
            cnt_d = burst_cnt + QW'(1);
        end else if (state == ST_OWNED && owner_req && !pick_found) begin
            cnt_d = eff_quota;
        end else if (pick_found) begin
            grant_d           = '0;
            grant_d[pick_idx] = 1'b1;
            idx_d             = pick_idx;
            ptr_d             = pick_idx;
            cnt_d             = QW'(1);
        end else begin
            grant_d = '0;
            idx_d   = '0;
            cnt_d   = '0;
        end
    end

    always_comb begin
        grant_valid = |grant;
        state       = grant_valid ? ST_OWNED : ST_IDLE;
    end

    assert property (@(posedge clk) disable iff (!rst) $onehot0(grant));
    assert property (@(posedge clk) disable iff (!rst) grant_valid == (|grant));
    assert property (@(posedge clk) disable iff (!rst) grant_valid |-> grant[grant_idx]);

endmodule

// File: doc/rr_arbiter_param.md
Name: rr_arbiter_param

Overview:
- N-requester round-robin arbiter with per-requester burst quotas and registered one-hot grant.
- Generalises the fixed 4-way FSM arbiter used on shared-resource ports to any width.
- Adds a valid output, grant release when requests drop, and bounded grant hold (quota).
- Sits in front of shared buses and memories; requesters hold `req` until served.

Parameters:
- N, 4, number of requesters (2..32).
- QW, 4, width of each per-requester quota field.
- IDXW, $clog2(N), width of the grant index (derived, not overridable).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req  in  N  request vector; bit i high = requester i wants access.
- quota  in  N*QW  field i = maximum consecutive grant cycles for requester i; 0 is treated as 1; quasi-static.
- grant  out  N  registered one-hot grant; all zeros when idle.
- grant_valid  out  1  high iff grant is non-zero.
- grant_idx  out  IDXW  index of the granted requester; 0 when idle.

Behaviour:
- Reset (rst=0, async):
  - grant=0, grant_valid=0, grant_idx=0.
  - Burst count burst_cnt=0.
  - Priority pointer ptr=N-1, so req[0] has highest priority on the first arbitration.
- State is implied by grant_valid:
  - IDLE (grant_valid=0).
  - OWNED (grant_valid=1, owner = grant_idx).
- Arbitration function pick(ptr, req): scan ptr+1, ptr+2, ... mod N and return the first set bit; no candidate if req==0.
- Latency: grant updates at the clock edge following the sampled req (1 cycle). Purely registered; no combinational path from req to grant.
- IDLE transitions:
  - If req!=0: grant the pick(ptr, req) result, set ptr=winner, burst_cnt=1, go OWNED.
  - Else: stay IDLE.
- OWNED, owner's req dropped:
  - Release immediately (same edge).
  - If other requests are pending: grant pick(ptr, req), reload burst_cnt=1.
  - If req==0: go IDLE with grant=0. ptr is kept, and there is no idle cycle between owners.
- OWNED, owner's req held and burst_cnt < eff_quota(owner): keep grant, burst_cnt+1.
- OWNED, owner's req held and burst_cnt >= eff_quota:
  - If any other req is set: grant pick(ptr, req & ~owner_bit), burst_cnt=1.
  - Otherwise: keep grant, burst_cnt saturates at eff_quota. There is no forced idle cycle.
- eff_quota(i) = (quota[i]==0) ? 1 : quota[i]. burst_cnt is QW bits wide and never wraps.
- Wrap-around: the scan rolls from index N-1 to 0.
- Fairness guarantees:
  - No requester that holds req continuously waits longer than the sum of the other requesters' effective quotas.
  - With all quotas = 1 and all req high, grants cycle 0,1,...,N-1,0.
- Simultaneous events: an owner drop and a new request on the same cycle resolve in a single edge, per the OWNED-dropped rules above.
- Reset mid-grant: grant clears asynchronously. After release, arbitration restarts from ptr=N-1.
- Invariants (assertions):
  - grant is $onehot0.
  - grant_valid == |grant.
  - grant_idx matches grant when valid.

Decomposition:
- Shared package rr_arb_pkg holds:
  - the index-width helper function;
  - the quota-field extraction function (slice i of quota);
  - the localparam for the pointer reset value (N-1).
- One combinational sub-module, rr_pick:
  - inputs: N-bit mask, IDXW pointer;
  - outputs: found flag, winner index.
  - Implementation: double-width rotate with a priority encoder.
- The top level keeps the registers: grant, ptr, burst_cnt.

Test Plan:
- Reset then idle: rst low → grant=0000, grant_valid=0, grant_idx=0. Release with req=0000 → stays idle for 10 cycles.
- Rotation: N=4, quota all 1, req=1111 held → grant sequence 0001,0010,0100,1000,0001 on consecutive cycles, each with a 1-cycle lag from the first request.
- Quota hold: quota={1,1,1,3} (req3 quota=3), req=1001 held from idle → grant 0001 ×1, then 1000 ×3, then 0001 ×1, then 1000 ×3, repeating.
- Early release and idle: req=0100 alone for 2 cycles, then req=0000 → grant 0100 for 2 cycles, then 0000 with grant_valid=0. Next req=0011 → grant 1000? No, 0001 (scan from ptr=2 wraps to 0).
- Sole requester saturation: quota[1]=2, req=0010 held for 8 cycles → grant=0010 for all 8 cycles, burst_cnt stays at 2, and there is no gap.
- Async reset mid-burst: assert rst while grant=0100 → grant=0000 within the same cycle. After release, with req=1111 → first grant=0001.
